// File: rtl/shared_reg_arb_pkg.sv
// Shared types and default sizing for the shared-register arbiter.
// Imported by the picker and the arbiter top level.
package shared_reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int DEF_N       = 4;
    localparam int DEF_WIDTH   = 8;
    localparam int DEF_HOLD    = 2;
    localparam int WCNT_W      = 16;
    localparam int HOLD_CNT_W  = 4;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first requester found searching
// upward from ptr+1 with wrap-around.
module rr_priority_picker
    import shared_reg_arb_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 valid,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] cand;

    // Scan farthest-first so the nearest candidate after ptr wins last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = N; k >= 1; k--) begin
            cand = IW'((int'(ptr) + k) % N);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter sharing one storage register between N requesters,
// with a programmable hold window after each write.
module shared_reg_arbiter
    import shared_reg_arb_pkg::*;
#(
    parameter int N           = DEF_N,
    parameter int WIDTH       = DEF_WIDTH,
    parameter int HOLD_CYCLES = DEF_HOLD
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N*WIDTH-1:0]   wdata,
    output logic [N-1:0]         gnt,
    output logic [WIDTH-1:0]     q,
    output logic [WIDTH-1:0]     q_bar,
    output logic [$clog2(N)-1:0] owner,
    output logic                 busy,
    output logic [WCNT_W-1:0]    wr_cnt
);

    localparam int IW = $clog2(N);
    localparam logic [HOLD_CNT_W-1:0] HOLD_LOAD =
        (HOLD_CYCLES > 0) ? HOLD_CNT_W'(HOLD_CYCLES - 1) : '0;

    state_t                state;
    state_t                state_d;
    logic [IW-1:0]         win;
    logic [IW-1:0]         win_d;
    logic [IW-1:0]         ptr;
    logic [HOLD_CNT_W-1:0] hold_cnt;
    logic [HOLD_CNT_W-1:0] hold_d;
    logic                  pick_valid;
    logic [IW-1:0]         pick_idx;
    logic                  wr_en;

    rr_priority_picker #(
        .N(N)
    ) u_picker (
        .req  (req),
        .ptr  (ptr),
        .valid(pick_valid),
        .idx  (pick_idx)
    );

    always_comb begin
        state_d = state;
        win_d   = win;
        hold_d  = hold_cnt;
        wr_en   = 1'b0;
        gnt     = '0;
        busy    = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    win_d   = pick_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                gnt[win] = 1'b1;
                state_d  = IDLE;
                // A withdrawn request just falls back to IDLE untouched.
                if (req[win]) begin
                    wr_en = 1'b1;
                    if (HOLD_CYCLES > 0) begin
                        state_d = HOLD;
                        hold_d  = HOLD_LOAD;
                    end
                end
            end
            HOLD: begin
                if (hold_cnt == '0) begin
                    state_d = IDLE;
                end else begin
                    hold_d = hold_cnt - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win      <= '0;
            hold_cnt <= '0;
            ptr      <= IW'(N - 1);
            q        <= '0;
            owner    <= '0;
            wr_cnt   <= '0;
        end else begin
            win      <= win_d;
            hold_cnt <= hold_d;
            if (wr_en) begin
                q      <= wdata[win*WIDTH +: WIDTH];
                owner  <= win;
                ptr    <= win;
                wr_cnt <= wr_cnt + 1'b1;
            end
        end
    end

    assign q_bar = ~q;

endmodule

// File: doc/shared_reg_arbiter.md
# shared_reg_arbiter

Round-robin arbiter and sequencer that shares one WIDTH-bit D-type storage register between N requesters. Each requester raises `req` with its write data. The arbiter grants one requester at a time and loads that requester's data into the register. It then enforces a programmable hold window before the next write. It sits between the requesting control blocks and the shared flip-flop bank, and exposes the stored value and its complement.

## Interface
- `N`, 4: number of requesters (2..8).
- `WIDTH`, 8: width of the shared register.
- `HOLD_CYCLES`, 2: minimum cycles the register holds a written value before the next grant (0..15).

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  N  per-requester write request, level; must stay high until granted.
- `wdata`  in  N*WIDTH  requester i's data on bits [i*WIDTH +: WIDTH].
- `gnt`  out  N  one-hot grant; high for exactly the one write cycle.
- `q`  out  WIDTH  shared register value.
- `q_bar`  out  WIDTH  bitwise complement of `q`, always.
- `owner`  out  clog2(N)  index of the most recent successful writer.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `wr_cnt`  out  16  successful writes since reset; wraps 0xFFFF→0.

## Operation
- States: IDLE, GRANT, HOLD.
- **IDLE:**
  - If any `req` bit is high, pick the winner round-robin. Search starts at `ptr+1` mod N and wraps.
  - Register the winner, assert its `gnt` bit next cycle, and go to GRANT.
  - If no `req` bit is high, stay in IDLE.
- **GRANT** (always exactly one cycle):
  - If `req[winner]` is still high:
    - `q` takes `wdata[winner]` at the clock edge that ends the cycle.
    - `owner` and `ptr` take the winner's index; `wr_cnt` increments.
    - Next state is HOLD if `HOLD_CYCLES` > 0, otherwise IDLE.
  - If `req[winner]` has dropped (withdrawn request):
    - No write occurs; `q`, `owner`, `ptr` and `wr_cnt` are unchanged.
    - Next state is IDLE.
- **HOLD:**
  - A down-counter is loaded with `HOLD_CYCLES`-1 on entry and decrements each cycle.
  - Leave for IDLE when the counter reaches 0.
  - `req` is ignored during HOLD.
- `gnt` is zero outside GRANT. It is never asserted for a requester whose `req` was low at the IDLE decision.
- Requests arriving during GRANT or HOLD are not lost; they are seen at the next IDLE decision because `req` is a level.
- `q_bar` is `~q` combinationally; it is never a separate stored value.

## Timing
- Reset values, asynchronous on `rst`=0:
  - `q`=0, `q_bar`=all ones, `gnt`=0, `busy`=0, `owner`=0, `wr_cnt`=0.
  - State IDLE, hold counter 0, `ptr`=N-1, so requester 0 has highest priority after reset.
- **Latency:**
  - `req` sampled high at edge k (FSM in IDLE) → `gnt` high for cycle k..k+1.
  - `q` is updated at edge k+1.
- **Throughput:** one write per `HOLD_CYCLES`+2 cycles. With `HOLD_CYCLES`=2, back-to-back writes land at edges k+1 and k+5.
- **Simultaneous requests:** exactly one grant, chosen by round-robin from `ptr`. A requester held high continuously is served at least once every N write slots.
- **Withdrawal:** a withdrawn request in GRANT costs 2 cycles with no side effects.
- **Reset mid-operation:** reset asserted in GRANT or HOLD forces `gnt`=0 immediately. Any in-flight write is dropped and all state returns to reset values.
- **Reset release:** leaving reset takes effect at the first rising edge with `rst`=1.

## Structure
- Package `shared_reg_arb_pkg`:
  - state enum {IDLE, GRANT, HOLD};
  - default constants for `N`, `WIDTH`, `HOLD_CYCLES`;
  - `wr_cnt` width constant (16).
- Sub-module `rr_priority_picker`: combinational. Takes `req[N]` and `ptr` and returns `valid` plus the winner index, searching from `ptr`+1 with wrap.
- Top level contains the FSM, hold counter, storage register, owner/pointer registers and write counter.

## Test plan
All scenarios use N=4, WIDTH=8, HOLD_CYCLES=2 unless stated.
- **Reset:** hold `rst`=0 and drive random `req`/`wdata` → `q`=0x00, `q_bar`=0xFF, `gnt`=0, `busy`=0, `wr_cnt`=0 throughout.
- **Single request:** `req`=0001 with `wdata[0]`=0xA5 → `gnt`=0001 for one cycle; `q`=0xA5, `q_bar`=0x5A and `owner`=0 after that edge; `busy` high 3 cycles; `wr_cnt`=1.
- **Round-robin fairness:** all four `req` held high with data 0x11/0x22/0x33/0x44 → grant order 0,1,2,3,0; grants spaced 4 cycles apart; `q` follows 0x11, 0x22, 0x33, 0x44, 0x11.
- **Withdrawal:** `req`=0100, then drop `req[2]` during GRANT → no `q` change, `wr_cnt` unchanged, FSM back in IDLE after 2 cycles. Then `req`=0110 → requester 1 is granted (ptr still 3, so the search starts at 0 and finds 1 first).
- **Reset mid-HOLD:** complete a write of 0x3C, then pull `rst` low during the second HOLD cycle → `q`=0 immediately; after release, `req`=1000 grants requester 0 first if also requesting (`req`=1001 → `gnt`=0001).
- **HOLD_CYCLES=0 variant:** `req`=0011 held high → grants alternate 0,1 every 2 cycles; `wr_cnt` increments every 2 cycles.
